// File: rtl/palette_pkg.sv
// rtl/palette_pkg.sv - shared constants and update-action enum for the palette selector
package palette_pkg;

    localparam int ERASE_CODE = 0;
    localparam int RESET_CODE = 1;

    typedef enum logic [2:0] {
        NONE,
        SELECT,
        ERASE_TOGGLE,
        STEP_NEXT,
        STEP_PREV
    } action_e;

endpackage

// File: rtl/button_release_detector.sv
// rtl/button_release_detector.sv - synchronise, debounce and emit a one-cycle pulse on button release
module button_release_detector #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic release_pulse
);

    // A one-cycle debounce still needs a 1-bit counter so the compare has something to look at.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q, stable_prev_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: sync chain, debounce counter, and falling-edge detect on the stable level.
    always_comb begin
        sync1_d       = raw;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        cnt_d         = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        stable_prev_d = stable_q;
        pulse_d       = stable_prev_q & ~stable_q;
    end

    // State registers; reset clears everything so a held button reads as a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            pulse_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            pulse_q       <= pulse_d;
            cnt_q         <= cnt_d;
        end
    end

    assign release_pulse = pulse_q;

endmodule

// File: rtl/palette_selector.sv
// rtl/palette_selector.sv - paint color code register driven by debounced buttons and direct select
module palette_selector #(
    parameter  int NUM_COLORS      = 8,
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int IDX_W           = $clog2(NUM_COLORS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             btn_erase,
    input  logic             sel_valid,
    input  logic [IDX_W-1:0] sel_code,
    output logic [IDX_W-1:0] color,
    output logic             erasing,
    output logic             changed
);

    import palette_pkg::*;

    localparam logic [IDX_W-1:0] ERASE     = IDX_W'(ERASE_CODE);
    localparam logic [IDX_W-1:0] START     = IDX_W'(RESET_CODE);
    localparam logic [IDX_W-1:0] MAX_CODE  = IDX_W'(NUM_COLORS - 1);
    localparam logic [IDX_W:0]   NUM_CODES = (IDX_W + 1)'(NUM_COLORS);

    logic next_ev, prev_ev, erase_ev;

    button_release_detector #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk           (clk),
        .reset         (reset),
        .raw           (btn_next),
        .release_pulse (next_ev)
    );

    button_release_detector #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk           (clk),
        .reset         (reset),
        .raw           (btn_prev),
        .release_pulse (prev_ev)
    );

    button_release_detector #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_erase (
        .clk           (clk),
        .reset         (reset),
        .raw           (btn_erase),
        .release_pulse (erase_ev)
    );

    action_e          action;
    logic [IDX_W-1:0] color_q, color_d;
    logic [IDX_W-1:0] last_paint_q, last_paint_d;
    logic             erasing_q, erasing_d;
    logic             changed_q, changed_d;

    // Priority resolver: an out-of-range select falls through to the button events.
    always_comb begin
        action = NONE;
        if (sel_valid && ({1'b0, sel_code} < NUM_CODES)) begin
            action = SELECT;
        end else if (erase_ev) begin
            action = ERASE_TOGGLE;
        end else if (next_ev && prev_ev) begin
            action = NONE;
        end else if (next_ev) begin
            action = STEP_NEXT;
        end else if (prev_ev) begin
            action = STEP_PREV;
        end
    end

    // Apply the resolved action; wrap points compare against the last code explicitly.
    always_comb begin
        color_d = color_q;
        case (action)
            SELECT:       color_d = sel_code;
            ERASE_TOGGLE: color_d = (color_q != ERASE) ? ERASE : last_paint_q;
            STEP_NEXT:    color_d = (color_q == MAX_CODE) ? ERASE : color_q + 1'b1;
            STEP_PREV:    color_d = (color_q == ERASE) ? MAX_CODE : color_q - 1'b1;
            default:      color_d = color_q;
        endcase
        last_paint_d = (color_q != ERASE) ? color_q : last_paint_q;
        erasing_d    = (color_d == ERASE);
        changed_d    = (color_d != color_q);
    end

    // Color, remembered paint color and the registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            color_q      <= START;
            last_paint_q <= START;
            erasing_q    <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            color_q      <= color_d;
            last_paint_q <= last_paint_d;
            erasing_q    <= erasing_d;
            changed_q    <= changed_d;
        end
    end

    assign color   = color_q;
    assign erasing = erasing_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_palette_selector.sv
// tb/tb_palette_selector.sv - self-checking bench for palette_selector (8 colors/4-cycle and 5 colors/1-cycle)
module tb_palette_selector;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_next, btn_prev, btn_erase;
    logic       sel_valid;
    logic [2:0] sel_code;
    logic [2:0] color_a, color_b;
    logic       erasing_a, erasing_b, changed_a, changed_b;

    always #5 clk = ~clk;

    palette_selector #(.NUM_COLORS(8), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .btn_erase(btn_erase), .sel_valid(sel_valid), .sel_code(sel_code),
        .color(color_a), .erasing(erasing_a), .changed(changed_a)
    );

    palette_selector #(.NUM_COLORS(5), .DEBOUNCE_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .btn_erase(btn_erase), .sel_valid(sel_valid), .sel_code(sel_code),
        .color(color_b), .erasing(erasing_b), .changed(changed_b)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    int   nc [2] = '{8, 5};
    int   dc [2] = '{4, 1};
    logic m_s1    [2][3];
    logic m_s2    [2][3];
    logic m_stab  [2][3];
    logic m_fell  [2][3];
    logic m_pulse [2][3];
    int   m_run   [2][3];
    int   m_color [2];
    int   m_last  [2];
    logic m_chg   [2];
    bit   model_live = 0;

    function automatic int next_color(int i, logic n, logic p, logic e);
        int c;
        c = m_color[i];
        if (sel_valid && int'(sel_code) < nc[i]) return int'(sel_code);
        if (e) return (c != 0) ? 0 : m_last[i];
        if (n && p) return c;
        if (n) return (c == nc[i] - 1) ? 0 : c + 1;
        if (p) return (c == 0) ? nc[i] - 1 : c - 1;
        return c;
    endfunction

    always @(posedge clk) begin
        logic raw [3];
        int   nxt;
        raw[0] = btn_next;
        raw[1] = btn_prev;
        raw[2] = btn_erase;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_color[i] = 1;
                m_last[i]  = 1;
                m_chg[i]   = 1'b0;
                for (int b = 0; b < 3; b++) begin
                    m_s1[i][b] = 1'b0; m_s2[i][b] = 1'b0; m_stab[i][b] = 1'b0;
                    m_fell[i][b] = 1'b0; m_pulse[i][b] = 1'b0; m_run[i][b] = 0;
                end
            end else begin
                nxt = next_color(i, m_pulse[i][0], m_pulse[i][1], m_pulse[i][2]);
                m_chg[i] = (nxt != m_color[i]);
                if (m_color[i] != 0) m_last[i] = m_color[i];
                m_color[i] = nxt;
                for (int b = 0; b < 3; b++) begin
                    m_pulse[i][b] = m_fell[i][b];
                    m_fell[i][b]  = 1'b0;
                    if (m_s2[i][b] != m_stab[i][b]) begin
                        m_run[i][b]++;
                        if (m_run[i][b] == dc[i]) begin
                            m_stab[i][b] = m_s2[i][b];
                            m_run[i][b]  = 0;
                            if (!m_stab[i][b]) m_fell[i][b] = 1'b1;
                        end
                    end else begin
                        m_run[i][b] = 0;
                    end
                    m_s2[i][b] = m_s1[i][b];
                    m_s1[i][b] = raw[b];
                end
            end
        end
        model_live = 1;
    end

    int chg_count_a = 0;

    always @(negedge clk) begin
        if (model_live) begin
            check("color_a",   color_a,   m_color[0]);
            check("erasing_a", erasing_a, int'(m_color[0] == 0));
            check("changed_a", changed_a, m_chg[0]);
            check("color_b",   color_b,   m_color[1]);
            check("erasing_b", erasing_b, int'(m_color[1] == 0));
            check("changed_b", changed_b, m_chg[1]);
            if (changed_a) chg_count_a++;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic press_release(logic n, logic p, logic e);
        btn_next = n; btn_prev = p; btn_erase = e;
        tick(8);
        btn_next = 1'b0; btn_prev = 1'b0; btn_erase = 1'b0;
        tick(12);
    endtask

    task automatic select(logic [2:0] code);
        sel_valid = 1'b1;
        sel_code  = code;
        tick(1);
        sel_valid = 1'b0;
    endtask

    int exp_a8 [8] = '{2, 3, 4, 5, 6, 7, 0, 1};
    int exp_b8 [8] = '{2, 3, 4, 0, 1, 2, 3, 4};
    int base;
    int first;

    initial begin
        reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; btn_erase = 1'b0;
        sel_valid = 1'b0; sel_code = 3'd0;
        do_reset();
        check("reset_color_a", color_a, 1);
        check("reset_erasing_a", erasing_a, 0);
        check("reset_changed_a", changed_a, 0);
        check("reset_color_b", color_b, 1);

        base = chg_count_a;
        for (int k = 0; k < 8; k++) begin
            press_release(1'b1, 1'b0, 1'b0);
            check("step_next_a", color_a, exp_a8[k]);
            check("step_next_b", color_b, exp_b8[k]);
        end
        check("next_changed_pulses_a", chg_count_a - base, 8);

        do_reset();
        press_release(1'b0, 1'b1, 1'b0);
        check("prev_wrap1_a", color_a, 0);
        check("prev_wrap1_b", color_b, 0);
        press_release(1'b0, 1'b1, 1'b0);
        check("prev_wrap2_a", color_a, 7);
        check("prev_wrap2_b", color_b, 4);
        press_release(1'b1, 1'b0, 1'b0);
        check("next_wrap_a", color_a, 0);
        check("next_wrap_b", color_b, 0);

        select(3'd3); tick(1);
        check("select3_a", color_a, 3);
        check("select3_b", color_b, 3);
        press_release(1'b0, 1'b0, 1'b1);
        check("erase_on_a", color_a, 0);
        check("erase_on_erasing_a", erasing_a, 1);
        press_release(1'b0, 1'b0, 1'b1);
        check("erase_off_a", color_a, 3);
        check("erase_off_b", color_b, 3);
        do_reset();
        press_release(1'b0, 1'b0, 1'b1);
        check("erase_from_reset_a", color_a, 0);
        press_release(1'b0, 1'b0, 1'b1);
        check("erase_back_reset_a", color_a, 1);
        check("erase_back_reset_b", color_b, 1);

        base = chg_count_a;
        btn_next = 1'b1; tick(8);
        btn_next = 1'b0; tick(3);
        btn_next = 1'b1; tick(8);
        check("glitch_color_a", color_a, 1);
        check("glitch_no_pulse_a", chg_count_a - base, 0);
        check("glitch_short_debounce_b", color_b, 2);
        btn_next = 1'b0;
        first = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (first < 0 && color_a != 3'd1) first = k;
        end
        tick(4);
        check("release_latency_a", first, 7);
        check("latency_color_a", color_a, 2);
        check("latency_color_b", color_b, 3);

        btn_next = 1'b1; tick(8);
        btn_next = 1'b0; tick(7);
        select(3'd6); tick(8);
        check("select_beats_next_a", color_a, 6);
        check("oob_select_next_b", color_b, 4);

        btn_prev = 1'b1; tick(8);
        btn_prev = 1'b0; tick(4);
        select(3'd6); tick(10);
        check("prev_after_same_select_a", color_a, 5);
        check("oob_select_prev_b", color_b, 3);

        base = chg_count_a;
        select(3'd5); tick(2);
        check("select_current_a", color_a, 5);
        check("select_current_no_pulse_a", chg_count_a - base, 0);
        check("select_oob_hold_b", color_b, 3);

        press_release(1'b1, 1'b1, 1'b0);
        check("next_prev_same_a", color_a, 5);
        check("next_prev_same_b", color_b, 3);

        btn_next = 1'b1; tick(8);
        btn_next = 1'b0; tick(3);
        reset = 1'b1; tick(1);
        reset = 1'b0; tick(20);
        check("mid_debounce_reset_a", color_a, 1);
        check("mid_debounce_reset_b", color_b, 1);

        btn_next = 1'b1; tick(8);
        reset = 1'b1; tick(2);
        reset = 1'b0; tick(8);
        btn_next = 1'b0; tick(12);
        check("held_through_reset_a", color_a, 2);
        check("held_through_reset_b", color_b, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
